fir_coef_sequencer: RTL
=======================

// Module: fir_coef_sequencer
// PURPOSE
//  Address-side master for the FP16 FIR coefficient ROM (a[5:0] -> q[15:0], combinational).
//  - On each accepted sample request, walks tap addresses 0..NTAPS-1.
//  - Registers each ROM word and streams it to the FP MAC with a valid/ready handshake.
//  - Each beat carries its tap index and a last flag.
//  - Sits between the sample front-end (request side) and the FPU MAC pipeline (coefficient side).
// PARAMETERS
//  NTAPS  64  taps per frame; must be >=2 and <=2**AW
//  AW     6   ROM address width
//  DW     16  coefficient width (FP16)
//  FOLD   0   1: ROM holds a symmetric table; rom_a = min(tap, NTAPS-1-tap)
// PORTS
//  clk      in   1   single clock, rising edge
//  rst_n    in   1   asynchronous, active-low reset
//  flush_i  in   1   synchronous abort of the current frame
//  s_valid  in   1   frame request valid
//  s_ready  out  1   frame request accepted when s_valid&s_ready
//  rom_a    out  AW  ROM address (combinational from tap counter)
//  rom_q    in   DW  ROM data, same cycle as rom_a
//  m_valid  out  1   coefficient beat valid
//  m_ready  in   1   MAC accepts beat
//  m_coef   out  DW  registered coefficient
//  m_tap    out  AW  tap index of m_coef
//  m_last   out  1   beat is tap NTAPS-1
//  busy_o   out  1   state==RUN or m_valid
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE, cnt=0.
//   - m_valid=0, m_coef=0, m_tap=0, m_last=0, busy_o=0, rom_a=0.
//   - s_ready=1 once reset is released.
//  FSM states IDLE and RUN:
//   - IDLE->RUN on s_valid&s_ready; cnt<=0.
//   - RUN->IDLE when the beat with cnt==NTAPS-1 is loaded, unless a new request is accepted in that same cycle.
//  load = state==RUN && (!m_valid || m_ready). On load:
//   - m_coef<=rom_q, m_tap<=cnt, m_last<=(cnt==NTAPS-1), m_valid<=1.
//   - cnt<=cnt+1, wrapping to 0 after NTAPS-1.
//  If m_valid&m_ready and no load: m_valid<=0.
//  m_coef, m_tap and m_last hold stable while m_valid&!m_ready.
//  s_ready = IDLE || (RUN && cnt==NTAPS-1 && load).
//   - Combinational through m_ready.
//   - Allows zero-bubble back-to-back frames: accepting in the last-load cycle keeps RUN and sets cnt<=0.
//  rom_a:
//   - FOLD=0: rom_a = cnt.
//   - FOLD=1: rom_a = (cnt < NTAPS-1-cnt) ? cnt : NTAPS-1-cnt.
//  Latency: request accepted at edge E0 -> first beat loaded at E1 if the output register is free.
//  Throughput: 1 beat/clk with m_ready=1.
//  flush_i=1 (priority over everything except reset):
//   - Next edge: state=IDLE, cnt=0, m_valid=0, m_last=0; the pending beat is dropped.
//   - s_ready=0 while flush_i=1; no request is accepted in that cycle.
//  Boundaries:
//   - Stall on the last beat: RUN holds with cnt==NTAPS-1 until it loads.
//   - m_ready=0 indefinitely: no beat lost or duplicated.
//   - A request in IDLE while the final beat of the previous frame is still stalled in the output register:
//     accepted; the new tap 0 loads only after that beat drains.
// STRUCTURE
//  Shared package fpu_const_pkg:
//   - FP16_W=16, COEF_AW=6, COEF_NTAPS=64.
//   - typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t.
//  Sub-module fir_coef_outreg: a one-entry valid/ready output register (coef, tap, last).
//  The FSM and counter stay in the top module.
// TESTING
//  Bench ROM model: rom_q = 16'h3C00 + rom_a.
//  1. Reset mid-frame at tap 20 -> all outputs 0 immediately; s_ready=1 after release; rom_a=0.
//  2. One request, m_ready=1 ->
//     - 64 consecutive beats; beat k: m_coef=3C00+k, m_tap=k.
//     - m_last only on tap 63; busy_o drops the cycle after.
//  3. m_ready pattern 1,0,1,0... -> taps 0..63 each delivered exactly once, in order; data stable during stalls.
//  4. s_valid held high, m_ready=1 -> 128 beats with no gap; m_tap wraps 63->0; exactly two m_last.
//  5. FOLD=1 -> tap 40 shows rom_a=23 and m_coef=3C17; tap 31 -> 31; tap 32 -> 31.
//  6. flush_i at tap 20 with m_valid=1 ->
//     - Next cycle: m_valid=0, s_ready=1.
//     - A new request restarts at tap 0, m_coef=3C00.

Source files
------------

// File: rtl/fpu_const_pkg.sv
// rtl/fpu_const_pkg.sv - shared FP16 coefficient constants and sequencer state type
package fpu_const_pkg;

  localparam int FP16_W     = 16;
  localparam int COEF_AW    = 6;
  localparam int COEF_NTAPS = 64;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/fir_coef_outreg.sv
// rtl/fir_coef_outreg.sv - one-entry valid/ready output register for coefficient beats
module fir_coef_outreg #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic [DW-1:0] coef_i,
  input  logic [AW-1:0] tap_i,
  input  logic          last_i,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_coef,
  output logic [AW-1:0] m_tap,
  output logic          m_last
);

  logic          valid_q, valid_d;
  logic [DW-1:0] coef_q, coef_d;
  logic [AW-1:0] tap_q, tap_d;
  logic          last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      coef_q  <= '0;
      tap_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      coef_q  <= coef_d;
      tap_q   <= tap_d;
      last_q  <= last_d;
    end
  end

  // Flush drops the pending beat; payload otherwise holds until a new load.
  always_comb begin
    valid_d = valid_q;
    coef_d  = coef_q;
    tap_d   = tap_q;
    last_d  = last_q;
    if (flush_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      coef_d  = coef_i;
      tap_d   = tap_i;
      last_d  = last_i;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  assign m_valid = valid_q;
  assign m_coef  = coef_q;
  assign m_tap   = tap_q;
  assign m_last  = last_q;

endmodule

// File: rtl/fir_coef_sequencer.sv
// rtl/fir_coef_sequencer.sv - walks FIR coefficient ROM taps per frame request and streams them out
module fir_coef_sequencer
  import fpu_const_pkg::*;
#(
  parameter int NTAPS = COEF_NTAPS,
  parameter int AW    = COEF_AW,
  parameter int DW    = FP16_W,
  parameter int FOLD  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_q,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_coef,
  output logic [AW-1:0] m_tap,
  output logic          m_last,
  output logic          busy_o
);

  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          load;
  logic          cnt_is_last;
  logic          accept;
  logic [AW-1:0] mirror;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A request accepted on the last-load edge keeps RUN and restarts at tap 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = SEQ_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = SEQ_RUN;
      cnt_d   = '0;
    end else if (load) begin
      if (cnt_is_last) begin
        state_d = SEQ_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_comb begin
    cnt_is_last = (cnt_q == LAST_TAP);
    load        = (state_q == SEQ_RUN) && (!m_valid || m_ready) && !flush_i;
    s_ready     = !flush_i && ((state_q == SEQ_IDLE) || (cnt_is_last && load));
    accept      = s_valid && s_ready;
    busy_o      = (state_q == SEQ_RUN) || m_valid;
    mirror      = LAST_TAP - cnt_q;
    rom_a       = cnt_q;
    if (FOLD != 0) begin
      rom_a = (cnt_q < mirror) ? cnt_q : mirror;
    end
  end

  fir_coef_outreg #(
    .AW(AW),
    .DW(DW)
  ) u_outreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .load_i  (load),
    .coef_i  (rom_q),
    .tap_i   (cnt_q),
    .last_i  (cnt_is_last),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_coef  (m_coef),
    .m_tap   (m_tap),
    .m_last  (m_last)
  );

endmodule
